// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB bus between N_REQ requesters. Requests are granted in
//   round-robin order. Each granted transfer runs one SETUP cycle and then
//   ACCESS cycles until the slave is ready. A transfer is aborted with an error
//   after TIMEOUT wait-state cycles.
//
//   Requester side:
//     req, req_write             per-requester request and direction
//     req_addr, req_wdata,       packed per-requester fields; requester i sits
//     req_id                     at [i*W +: W]
//     grant                      one-hot owner of the current transfer
//     done                       one-cycle completion pulse to the owner
//     err                        qualifies done: 1 = timeout abort
//     rdata_out                  read data captured at completion
//   APB side:
//     sel, sel_id, enable, write, addr, wdata   registered bus outputs
//     rdata, ready                              slave response
module apb_master_arbiter #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*2-1:0]        req_id,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata_out,
  output logic                      sel,
  output logic [1:0]                sel_id,
  output logic                      enable,
  output logic                      write,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W-1:0]         rdata,
  input  logic                      ready
);

  localparam int PTR_W = (N_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              r_state, w_state_n;
  logic [PTR_W-1:0]    r_ptr, w_ptr_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [N_REQ-1:0]    r_grant, w_grant_n;
  logic [N_REQ-1:0]    r_done, w_done_n;
  logic                r_err, w_err_n;
  logic [DATA_W-1:0]   r_rdata, w_rdata_n;
  logic                r_sel, w_sel_n;
  logic                r_en, w_en_n;
  logic                r_write, w_write_n;
  logic [1:0]          r_sel_id, w_sel_id_n;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [DATA_W-1:0]   r_wdata, w_wdata_n;

  // Arbitration result
  logic                w_any;
  logic [PTR_W-1:0]    w_win;
  logic [N_REQ-1:0]    w_win_oh;
  logic                w_win_write;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;
  logic [1:0]          w_win_id;

  // Pass 0 scans requesters above the pointer, pass 1 wraps to those at or
  // below it, giving the first set bit from pointer+1 modulo N_REQ.
  always_comb begin
    w_any       = 1'b0;
    w_win       = '0;
    w_win_oh    = '0;
    w_win_write = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    w_win_id    = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!w_any && req[i] && ((p == 0) == (i > 32'(r_ptr)))) begin
          w_any       = 1'b1;
          w_win       = PTR_W'(i);
          w_win_oh[i] = 1'b1;
          w_win_write = req_write[i];
          w_win_addr  = req_addr[i*ADDR_W +: ADDR_W];
          w_win_wdata = req_wdata[i*DATA_W +: DATA_W];
          w_win_id    = req_id[i*2 +: 2];
        end
      end
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_ptr_n    = r_ptr;
    w_cnt_n    = r_cnt;
    w_grant_n  = r_grant;
    w_done_n   = '0;
    w_err_n    = 1'b0;
    w_rdata_n  = r_rdata;
    w_sel_n    = r_sel;
    w_en_n     = r_en;
    w_write_n  = r_write;
    w_sel_id_n = r_sel_id;
    w_addr_n   = r_addr;
    w_wdata_n  = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        w_sel_n   = 1'b0;
        w_en_n    = 1'b0;
        w_grant_n = '0;
        if (w_any) begin
          w_state_n  = S_SETUP;
          w_sel_n    = 1'b1;
          w_grant_n  = w_win_oh;
          w_ptr_n    = w_win;
          w_write_n  = w_win_write;
          w_addr_n   = w_win_addr;
          w_wdata_n  = w_win_wdata;
          w_sel_id_n = w_win_id;
        end
      end
      S_SETUP: begin
        w_state_n = S_ACCESS;
        w_en_n    = 1'b1;
        w_cnt_n   = '0;
      end
      S_ACCESS: begin
        if (ready) begin
          w_done_n  = r_grant;
          if (!r_write) w_rdata_n = rdata;
          w_grant_n = '0;
          w_sel_n   = 1'b0;
          w_en_n    = 1'b0;
          w_state_n = S_IDLE;
        end else begin
          if (r_cnt != CNT_MAX) w_cnt_n = r_cnt + 1'b1;
          if (w_cnt_n == CNT_TO) begin
            w_done_n  = r_grant;
            w_err_n   = 1'b1;
            w_grant_n = '0;
            w_sel_n   = 1'b0;
            w_en_n    = 1'b0;
            w_state_n = S_IDLE;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr    <= PTR_RST;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_sel    <= 1'b0;
      r_en     <= 1'b0;
      r_write  <= 1'b0;
      r_sel_id <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_ptr    <= w_ptr_n;
      r_cnt    <= w_cnt_n;
      r_grant  <= w_grant_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
      r_rdata  <= w_rdata_n;
      r_sel    <= w_sel_n;
      r_en     <= w_en_n;
      r_write  <= w_write_n;
      r_sel_id <= w_sel_id_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign err       = r_err;
  assign rdata_out = r_rdata;
  assign sel       = r_sel;
  assign sel_id    = r_sel_id;
  assign enable    = r_en;
  assign write     = r_write;
  assign addr      = r_addr;
  assign wdata     = r_wdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: transaction-level reference model, per-cycle
// compare process, directed scenarios with literal expectations, then a
// randomized requester/ready phase.
module tb_apb_master_arbiter;
  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req, req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*2-1:0]    req_id;
  logic [N-1:0]      grant, done;
  logic              err, sel, enable, write, ready;
  logic [DW-1:0]     rdata_out, wdata, rdata;
  logic [1:0]        sel_id;
  logic [AW-1:0]     addr;

  apb_master_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_id(req_id), .grant(grant), .done(done), .err(err),
    .rdata_out(rdata_out), .sel(sel), .sel_id(sel_id), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_chk, n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    $display("FAIL %s: event not seen within cycle budget at %0t", nm, $time);
  endtask

  // APB slave memory driven by the DUT bus
  logic [DW-1:0] slv_mem [0:255];
  assign rdata = slv_mem[addr];
  always @(posedge clk) if (sel && enable && ready && write) slv_mem[addr] <= wdata;

  // Ready generator: wait_n < 0 = random; otherwise ready rises on the
  // (wait_n+1)-th ACCESS cycle. Outside ACCESS ready is random noise.
  int wait_n, acc_cnt;
  always @(negedge clk) begin
    if (wait_n < 0 || !enable) begin
      ready   = 1'($urandom_range(0, 1));
      acc_cnt = 0;
    end else begin
      ready   = (acc_cnt >= wait_n);
      acc_cnt++;
    end
  end

  // Reference model: one in-flight transaction with its age in cycles
  bit            m_busy;
  int            m_owner, m_age, m_waits, m_ptr, m_c;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    m_id;
  logic [N-1:0]  m_done;
  logic          m_err;
  logic [DW-1:0] m_mem [0:255];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_ptr = N - 1; m_done = '0; m_err = 0; m_rdata = '0;
      m_age = 0; m_waits = 0; m_owner = 0;
      m_write = 0; m_addr = '0; m_wdata = '0; m_id = '0;
    end else begin
      m_done = '0;
      m_err  = 0;
      if (!m_busy) begin
        for (int j = 1; j <= N; j++) begin
          m_c = (m_ptr + j) % N;
          if (!m_busy && req[m_c]) begin
            m_busy = 1; m_owner = m_c; m_ptr = m_c; m_age = 0;
            m_write = req_write[m_c];
            m_addr  = req_addr[m_c*AW +: AW];
            m_wdata = req_wdata[m_c*DW +: DW];
            m_id    = req_id[m_c*2 +: 2];
          end
        end
      end else if (m_age == 0) begin
        m_age = 1; m_waits = 0;
      end else if (ready) begin
        m_done[m_owner] = 1'b1;
        if (m_write) m_mem[m_addr] = m_wdata;
        else         m_rdata = m_mem[m_addr];
        m_busy = 0;
      end else begin
        m_waits++;
        if (m_waits == TO) begin
          m_done[m_owner] = 1'b1; m_err = 1'b1; m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("sel", sel, m_busy);
    chk("enable", enable, m_busy && m_age > 0);
    chk("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("rdata_out", rdata_out, m_rdata);
    if (m_busy) begin
      chk("write", write, m_write);
      chk("addr", addr, m_addr);
      chk("wdata", wdata, m_wdata);
      chk("sel_id", sel_id, m_id);
    end
  end

  // Randomized requesters
  bit auto_req;
  always @(negedge clk) begin
    if (auto_req) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (done[i]) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_write[i]           = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW]   = 8'($urandom_range(0, 15));
          req_wdata[i*DW +: DW]  = 8'($urandom);
          req_id[i*2 +: 2]       = 2'($urandom_range(0, 3));
          req[i]                 = 1'b1;
        end
      end
    end
  end

  task automatic run_xfer(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [1:0] id, output int en_cyc, output logic e, output logic [7:0] rd);
    en_cyc = 0; e = 0; rd = 0;
    req_write[i] = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_id[i*2 +: 2]      = id;
    req[i] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (enable) en_cyc++;
      if (done[i]) begin
        e = err; rd = rdata_out; req[i] = 1'b0;
        return;
      end
    end
    bound_fail("xfer_done");
    req[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done[i]) begin
        req[i] = 1'b0;
        return;
      end
    end
    bound_fail("wait_done");
    req[i] = 1'b0;
  endtask

  int          en_c, ng, dcount;
  logic        e_v, psel;
  logic [7:0]  rd_v;
  logic [N-1:0] gq [0:3];

  initial begin
    n_chk = 0; n_pass = 0;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_id = '0;
    wait_n = 0; acc_cnt = 0; auto_req = 0; ready = 0;
    for (int a = 0; a < 256; a++) begin slv_mem[a] = '0; m_mem[a] = '0; end
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sel", sel, 0); chk("rst_enable", enable, 0); chk("rst_grant", grant, 0);
    chk("rst_done", done, 0); chk("rst_rdata_out", rdata_out, 0);
    reset = 1'b0;

    // Write, no wait states
    req_write[0] = 1; req_addr[7:0] = 8'd6; req_wdata[7:0] = 8'd5; req_id[1:0] = 2'd1; req[0] = 1;
    @(negedge clk);
    chk("t1_setup_sel", sel, 1); chk("t1_setup_en", enable, 0); chk("t1_grant", grant, 1);
    chk("t1_addr", addr, 6); chk("t1_wdata", wdata, 5); chk("t1_id", sel_id, 1); chk("t1_write", write, 1);
    @(negedge clk);
    chk("t1_access_sel", sel, 1); chk("t1_access_en", enable, 1);
    @(negedge clk);
    chk("t1_done", done, 1); chk("t1_err", err, 0); chk("t1_idle_sel", sel, 0);
    req[0] = 0;
    chk("t1_mem6", slv_mem[6], 5);

    // Read back
    run_xfer(0, 0, 8'd6, 8'd0, 2'd1, en_c, e_v, rd_v);
    chk("t2_rdata", rd_v, 5); chk("t2_err", e_v, 0); chk("t2_en_cycles", en_c, 1);

    // Wait states, from requester 1
    wait_n = 5;
    run_xfer(1, 1, 8'd5, 8'd4, 2'd2, en_c, e_v, rd_v);
    chk("t3_en_cycles", en_c, 6); chk("t3_err", e_v, 0); chk("t3_mem5", slv_mem[5], 4);
    dcount = 0;
    repeat (3) begin @(negedge clk); if (done != 0) dcount++; end
    chk("t3_single_done", dcount, 0);

    // Contention, both requests held
    wait_n = 0;
    req_write = 2'b11; req_addr = {8'd11, 8'd10}; req_wdata = {8'hB2, 8'hA1}; req_id = {2'd3, 2'd0};
    req = 2'b11; ng = 0; psel = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (sel && !psel && ng < 4) begin gq[ng] = grant; ng++; end
      psel = sel;
      if (ng == 4 && done[1]) break;
    end
    req = '0;
    chk("t4_ngrants", ng, 4);
    chk("t4_g0", gq[0], 1); chk("t4_g1", gq[1], 2); chk("t4_g2", gq[2], 1); chk("t4_g3", gq[3], 2);

    // Timeout, then a normal transfer
    wait_n = 1000;
    run_xfer(0, 0, 8'd3, 8'd0, 2'd0, en_c, e_v, rd_v);
    chk("t5_en_cycles", en_c, TO); chk("t5_err", e_v, 1); chk("t5_rdata_hold", rd_v, 5);
    wait_n = 0;
    run_xfer(0, 0, 8'd5, 8'd0, 2'd0, en_c, e_v, rd_v);
    chk("t5_next_rdata", rd_v, 4); chk("t5_next_err", e_v, 0);

    // Reset in the middle of ACCESS
    wait_n = 1000;
    req_write[1] = 1; req_addr[15:8] = 8'd20; req_wdata[15:8] = 8'h77; req[1] = 1;
    psel = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (enable) begin psel = 1; break; end
    end
    if (!psel) bound_fail("t6_enable");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_sel", sel, 0); chk("t6_enable", enable, 0); chk("t6_grant", grant, 0); chk("t6_done", done, 0);
    @(negedge clk);
    reset = 1'b0; wait_n = 0;
    req_write[0] = 0; req_addr[7:0] = 8'd6; req[0] = 1;
    @(negedge clk);
    chk("t6_first_grant", grant, 1);
    wait_done(0);
    wait_done(1);

    // Randomized traffic
    wait_n = -1; auto_req = 1;
    repeat (4000) @(negedge clk);
    auto_req = 0;
    psel = 1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!sel) begin req = '0; psel = 0; break; end
    end
    if (psel) bound_fail("drain");
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
